// File: rtl/triangle_loader.sv
// Drains a header plus 12-word triangle records from a standard FIFO and issues one wide write
// per triangle. Optional trailing XOR checksum when TRIANGLE_LOADER_CHECKSUM_EN is defined.
module triangle_loader #(
  parameter int D_BITS = 32,
  parameter int M_BITS = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_empty,
  output logic                 in_rd_en,
  input  logic [D_BITS-1:0]    word_in,
  output logic [M_BITS-1:0]    mem_wr_addr,
  output logic                 mem_wr_en,
  output logic [12*D_BITS-1:0] mem_din,
  output logic                 busy,
  output logic                 load_done,
  output logic [M_BITS:0]      tri_count,
  output logic                 hdr_clamped,
  output logic                 checksum_err
);

  localparam int NW = M_BITS + 1;
  localparam int TW = M_BITS + 4;
  localparam logic [NW-1:0]     CAP_N = {1'b1, {M_BITS{1'b0}}};
  localparam logic [D_BITS-1:0] CAP_W = D_BITS'(CAP_N);

`ifdef TRIANGLE_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_CHK, S_DONE} state_t;
  localparam state_t S_TAIL = S_CHK;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_DONE} state_t;
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t                state_reg, state_next;
  logic                  rd_valid_reg;
  logic [TW-1:0]         req_cnt_reg, total_reg;
  logic [NW-1:0]         n_reg, tri_count_reg;
  logic [3:0]            word_idx_reg;
  logic [D_BITS-1:0]     rec_reg [0:10];
  logic [11*D_BITS-1:0]  rec_flat;
  logic [12*D_BITS-1:0]  mem_din_reg;
  logic                  mem_wr_en_reg;
  logic [M_BITS-1:0]     mem_wr_addr_reg;
  logic                  hdr_clamped_reg;
  logic                  owed, hdr_big, accept_start, load_word;
  logic [NW-1:0]         hdr_n;

  assign hdr_big      = word_in > CAP_W;
  assign hdr_n        = hdr_big ? CAP_N : word_in[NW-1:0];
  assign accept_start = start && (state_reg == S_IDLE || state_reg == S_DONE);
  assign load_word    = rd_valid_reg && (state_reg == S_LOAD);

  always_comb begin
    state_next = state_reg;
    owed       = 1'b0;
    case (state_reg)
      S_IDLE: if (start) state_next = S_HDR;
      S_HDR: begin
        owed = (req_cnt_reg == '0);
        if (rd_valid_reg) state_next = (word_in == '0) ? S_TAIL : S_LOAD;
      end
      S_LOAD: begin
        owed = (req_cnt_reg < total_reg);
        // Leave only once the final strobe is on the port, so load_done trails it by a cycle.
        if (mem_wr_en_reg && tri_count_reg == n_reg) state_next = S_TAIL;
      end
`ifdef TRIANGLE_LOADER_CHECKSUM_EN
      S_CHK: begin
        owed = (req_cnt_reg == '0);
        if (rd_valid_reg) state_next = S_DONE;
      end
`endif
      S_DONE: if (start) state_next = S_HDR;
      default: state_next = S_IDLE;
    endcase
    in_rd_en = owed && !in_empty;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      rd_valid_reg    <= 1'b0;
      req_cnt_reg     <= '0;
      total_reg       <= '0;
      n_reg           <= '0;
      tri_count_reg   <= '0;
      word_idx_reg    <= '0;
      mem_din_reg     <= '0;
      mem_wr_en_reg   <= 1'b0;
      mem_wr_addr_reg <= '0;
      hdr_clamped_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rd_valid_reg  <= in_rd_en;
      mem_wr_en_reg <= 1'b0;
      // Request counter restarts on every state change; each state owes its own words.
      if (state_next != state_reg) req_cnt_reg <= '0;
      else if (in_rd_en)           req_cnt_reg <= req_cnt_reg + 1'b1;
      if (accept_start) begin
        tri_count_reg   <= '0;
        hdr_clamped_reg <= 1'b0;
        word_idx_reg    <= '0;
      end
      if (rd_valid_reg && state_reg == S_HDR) begin
        n_reg           <= hdr_n;
        total_reg       <= TW'({hdr_n, 3'b000}) + TW'({hdr_n, 2'b00});
        hdr_clamped_reg <= hdr_big;
      end
      if (load_word) begin
        if (word_idx_reg == 4'd11) begin
          word_idx_reg    <= '0;
          mem_din_reg     <= {word_in, rec_flat};
          mem_wr_en_reg   <= 1'b1;
          mem_wr_addr_reg <= tri_count_reg[M_BITS-1:0];
          tri_count_reg   <= tri_count_reg + 1'b1;
        end else begin
          word_idx_reg <= word_idx_reg + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (load_word && word_idx_reg != 4'd11) rec_reg[word_idx_reg] <= word_in;
  end

  for (genvar gi = 0; gi < 11; gi++) begin : g_lane
    assign rec_flat[gi*D_BITS +: D_BITS] = rec_reg[gi];
  end

`ifdef TRIANGLE_LOADER_CHECKSUM_EN
  logic [D_BITS-1:0] xor_reg;
  logic              checksum_err_reg;

  always_ff @(posedge clock) begin
    if (reset || accept_start) begin
      xor_reg          <= '0;
      checksum_err_reg <= 1'b0;
    end else begin
      if (load_word) xor_reg <= xor_reg ^ word_in;
      if (rd_valid_reg && state_reg == S_CHK) checksum_err_reg <= (word_in != xor_reg);
    end
  end

  assign checksum_err = checksum_err_reg;
`else
  assign checksum_err = 1'b0;
`endif

  assign mem_wr_addr = mem_wr_addr_reg;
  assign mem_wr_en   = mem_wr_en_reg;
  assign mem_din     = mem_din_reg;
  assign busy        = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign load_done   = (state_reg == S_DONE);
  assign tri_count   = tri_count_reg;
  assign hdr_clamped = hdr_clamped_reg;

endmodule

// File: tb/tb_triangle_loader.sv
// Randomized bench for triangle_loader: a FIFO queue feeds the DUT and a stream-level model
// predicts every write, its cycle, the word count consumed and the final status.
module tb_triangle_loader;
  localparam int D   = 32;
  localparam int M   = 2;
  localparam int CAP = 4;
  localparam int RW  = 12 * D;
`ifdef TRIANGLE_LOADER_CHECKSUM_EN
  localparam int CHK_EN = 1;
`else
  localparam int CHK_EN = 0;
`endif

  logic          clock = 1'b0;
  logic          reset, start, in_empty, in_rd_en, mem_wr_en, busy, load_done;
  logic          hdr_clamped, checksum_err;
  logic [D-1:0]  word_in;
  logic [M-1:0]  mem_wr_addr;
  logic [RW-1:0] mem_din;
  logic [M:0]    tri_count;

  triangle_loader #(.D_BITS(D), .M_BITS(M)) dut (
    .clock(clock), .reset(reset), .start(start), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .word_in(word_in), .mem_wr_addr(mem_wr_addr), .mem_wr_en(mem_wr_en), .mem_din(mem_din),
    .busy(busy), .load_done(load_done), .tri_count(tri_count), .hdr_clamped(hdr_clamped),
    .checksum_err(checksum_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [D-1:0]  fifo_q[$];
  logic [RW-1:0] exp_rec_q[$];
  int            exp_wcyc_q[$];
  int            cyc, pos, n_eff, writes, consumed, done_ref, last_wr_cyc, pushed;
  bit            thru_chk, exp_cerr;
  logic [RW-1:0] cur_rec, last_rec;
  logic [D-1:0]  xor_acc;

  // Stream model: header, then 12*n_eff payload words, then (optionally) the checksum word.
  task automatic note_word(input logic [D-1:0] w);
    if (pos == 0) begin
      if (n_eff == 0 && CHK_EN == 0) done_ref = cyc + 1;
    end else if (pos <= 12 * n_eff) begin
      cur_rec[D*((pos-1)%12) +: D] = w;
      xor_acc ^= w;
      if ((pos - 1) % 12 == 11) begin
        exp_rec_q.push_back(cur_rec);
        exp_wcyc_q.push_back(cyc + 1);
      end
    end else if (pos == 12 * n_eff + 1 && CHK_EN == 1) begin
      exp_cerr = (w != xor_acc);
      done_ref = cyc + 1;
    end
    pos++;
    consumed++;
  endtask

  task automatic note_write();
    logic [RW-1:0] rec;
    int wc;
    writes++;
    if (exp_rec_q.size() == 0) begin
      check("unexpected_write", RW'(mem_wr_en), RW'(0));
    end else begin
      rec = exp_rec_q.pop_front();
      wc  = exp_wcyc_q.pop_front();
      check("wr_addr", RW'(mem_wr_addr), RW'(writes - 1));
      check("wr_data", mem_din, rec);
      check("wr_cycle", RW'(cyc), RW'(wc));
      if (thru_chk && writes > 1) check("wr_interval", RW'(cyc - last_wr_cyc), RW'(12));
      last_wr_cyc = cyc;
      last_rec    = rec;
      if (writes == n_eff && CHK_EN == 0) done_ref = cyc + 1;
    end
  endtask

  task automatic tick(input bit gaps, input bit poke);
    bit rd;
    logic [D-1:0] w;
    in_empty = (fifo_q.size() == 0) || (gaps && ($urandom_range(0, 2) == 0));
    @(negedge clock);
    rd = in_rd_en;
    if (rd) check("rd_while_empty", RW'(in_empty), RW'(0));
    if (poke && busy && $urandom_range(0, 7) == 0) start = 1'b1;
    @(posedge clock);
    #1;
    cyc++;
    start = 1'b0;
    if (rd && !in_empty) begin
      w = fifo_q.pop_front();
      word_in = w;
      note_word(w);
    end
    if (mem_wr_en) note_write();
  endtask

  task automatic prep_stream(input int header, input int npay, input bit seq,
                             input logic [D-1:0] corrupt, input int tail);
    logic [D-1:0] w, x;
    fifo_q.delete();
    exp_rec_q.delete();
    exp_wcyc_q.delete();
    x = '0;
    fifo_q.push_back(D'(header));
    for (int i = 0; i < npay; i++) begin
      w = seq ? D'(i) : D'($urandom());
      x ^= w;
      fifo_q.push_back(w);
    end
    if (CHK_EN == 1) fifo_q.push_back(x ^ corrupt);
    for (int i = 0; i < tail; i++) fifo_q.push_back(D'($urandom()));
    pushed   = fifo_q.size();
    n_eff    = (header > CAP) ? CAP : header;
    pos      = 0;
    writes   = 0;
    consumed = 0;
    xor_acc  = '0;
    exp_cerr = 1'b0;
    done_ref = -1;
    cur_rec  = '0;
    last_rec = '0;
  endtask

  task automatic run_load(input int header, input int npay, input bit seq,
                          input logic [D-1:0] corrupt, input int tail,
                          input bit gaps, input bit thru);
    int n;
    int owed_words;
    prep_stream(header, npay, seq, corrupt, tail);
    owed_words = 1 + 12 * n_eff + CHK_EN;
    thru_chk   = thru;
    start = 1'b1;
    tick(gaps, 0);
    check("busy_on_start", RW'(busy), RW'(1));
    check("done_low_on_start", RW'(load_done), RW'(0));
    n = 0;
    while (!load_done && n < 3000) begin
      tick(gaps, 1);
      n++;
    end
    check("load_timeout", RW'(load_done), RW'(1));
    check("done_cycle", RW'(cyc), RW'(done_ref));
    check("busy_in_done", RW'(busy), RW'(0));
    check("tri_count", RW'(tri_count), RW'(n_eff));
    check("hdr_clamped", RW'(hdr_clamped), RW'(header > CAP));
    check("writes", RW'(writes), RW'(n_eff));
    check("consumed", RW'(consumed), RW'(owed_words));
    check("checksum_err", RW'(checksum_err), RW'(exp_cerr));
    if (n_eff > 0) check("din_hold", mem_din, last_rec);
    repeat (6) tick(0, 0);
    check("fifo_left", RW'(fifo_q.size()), RW'(pushed - owed_words));
    check("done_holds", RW'(load_done), RW'(1));
    $display("LOAD hdr=%0d n=%0d writes=%0d consumed=%0d clamped=%0b cerr=%0b gaps=%0b",
             header, n_eff, writes, consumed, hdr_clamped, checksum_err, gaps);
    fifo_q.delete();
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_in_rd_en"}, RW'(in_rd_en), RW'(0));
    check({pfx, "_mem_wr_en"}, RW'(mem_wr_en), RW'(0));
    check({pfx, "_mem_wr_addr"}, RW'(mem_wr_addr), RW'(0));
    check({pfx, "_mem_din"}, mem_din, RW'(0));
    check({pfx, "_busy"}, RW'(busy), RW'(0));
    check({pfx, "_load_done"}, RW'(load_done), RW'(0));
    check({pfx, "_tri_count"}, RW'(tri_count), RW'(0));
    check({pfx, "_hdr_clamped"}, RW'(hdr_clamped), RW'(0));
    check({pfx, "_checksum_err"}, RW'(checksum_err), RW'(0));
  endtask

  initial begin
    int h, n;
    reset    = 1'b1;
    start    = 1'b0;
    in_empty = 1'b1;
    word_in  = '0;
    cyc      = 0;
    thru_chk = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check_reset_values("rst");

    // Single triangle with words 0..11 and a trailing word that must stay in the FIFO.
    run_load(1, 12, 1, '0, 1, 0, 0);
    check("lane0", RW'(mem_din[31:0]), RW'(0));
    check("lane11", RW'(mem_din[383:352]), RW'(32'hB));

    run_load(3, 36, 0, '0, 1, 1, 0);
    run_load(3, 36, 0, '0, 0, 0, 1);
    run_load(0, 0, 0, '0, 2, 0, 0);

    // Reset after word 7 of triangle 1, with a coincident start that must be ignored.
    prep_stream(2, 24, 0, '0, 0);
    thru_chk = 1'b0;
    start = 1'b1;
    tick(1, 0);
    n = 0;
    while (consumed < 21 && n < 2000) begin
      tick(1, 0);
      n++;
    end
    check("reach_word7", RW'(consumed), RW'(21));
    reset = 1'b1;
    start = 1'b1;
    tick(0, 0);
    reset = 1'b0;
    check_reset_values("midrst");
    repeat (20) tick(0, 0);
    check("writes_after_reset", RW'(writes), RW'(1));
    check("idle_after_reset", RW'(busy), RW'(0));
    $display("RESET mid-load writes=%0d consumed=%0d", writes, consumed);
    fifo_q.delete();
    run_load(2, 24, 0, '0, 1, 1, 0);

    // Header beyond capacity.
    run_load(9, 108, 0, '0, 0, 1, 0);

    repeat (4) begin
      h = $urandom_range(0, 6);
      run_load(h, 12 * h, 0, '0, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
    end

`ifdef TRIANGLE_LOADER_CHECKSUM_EN
    run_load(1, 12, 0, 32'h0000_0100, 0, 0, 0);
    check("cerr_set", RW'(checksum_err), RW'(1));
    run_load(1, 12, 0, '0, 0, 1, 0);
    check("cerr_clear", RW'(checksum_err), RW'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
